// File: rtl/btn_pkg.sv
// btn_pkg: shared state encoding, counter widths and a saturating increment
// helper for the button debouncer. Optional feature macro: BTN_AUTOREPEAT_EN.
package btn_pkg;

   localparam int CNT_W = 4;
   localparam int REP_W = 16;

   typedef enum logic [1:0] {
      RELEASED     = 2'd0,
      PRESS_PEND   = 2'd1,
      PRESSED      = 2'd2,
      RELEASE_PEND = 2'd3
   } btn_state_e;

   // Stability counter increment that sticks at all-ones instead of wrapping.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value);
      if (value == {CNT_W{1'b1}}) begin
         return value;
      end
      return value + CNT_W'(1);
   endfunction

endpackage

// File: rtl/btn_fsm.sv
// btn_fsm: per-button debounce state machine advancing only on sample_tick.
// With BTN_AUTOREPEAT_EN defined, a held button also emits repeat presses.
module btn_fsm
   import btn_pkg::*;
#(
   parameter int STABLE_SAMPLES = 4
`ifdef BTN_AUTOREPEAT_EN
   ,
   parameter int REPEAT_DELAY   = 50,
   parameter int REPEAT_PERIOD  = 10
`endif
) (
   input  logic clk,
   input  logic rst,
   input  logic sample_tick,
   input  logic btn_sync,
   output logic btn_level,
   output logic btn_press,
   output logic btn_release
);

   localparam logic [CNT_W-1:0] STABLE_CNT = CNT_W'(STABLE_SAMPLES);

   btn_state_e       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] run_len;
   logic             level_q, level_d;
   logic             press_q, press_d;
   logic             release_q, release_d;

`ifdef BTN_AUTOREPEAT_EN
   localparam logic [REP_W-1:0] DELAY_CNT  = REP_W'(REPEAT_DELAY);
   localparam logic [REP_W-1:0] PERIOD_CNT = REP_W'(REPEAT_PERIOD);

   logic [REP_W-1:0] rep_q, rep_d;
   logic [REP_W-1:0] rep_inc;
   logic             armed_q, armed_d;
`endif

   // Next-state logic: a pending run of differing samples is accepted once it
   // reaches STABLE_SAMPLES; the first differing sample counts as run length 1,
   // so a threshold of 1 completes on that very tick.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      level_d   = level_q;
      press_d   = 1'b0;
      release_d = 1'b0;
      run_len   = sat_inc(cnt_q);
`ifdef BTN_AUTOREPEAT_EN
      rep_d     = rep_q;
      armed_d   = armed_q;
      rep_inc   = rep_q + REP_W'(1);
`endif
      if (sample_tick) begin
         case (state_q)
            RELEASED, PRESS_PEND: begin
               if (!btn_sync) begin
                  state_d = RELEASED;
                  cnt_d   = '0;
               end else begin
                  if (state_q == RELEASED) begin
                     run_len = CNT_W'(1);
                  end
                  if (run_len == STABLE_CNT) begin
                     state_d = PRESSED;
                     cnt_d   = '0;
                     level_d = 1'b1;
                     press_d = 1'b1;
`ifdef BTN_AUTOREPEAT_EN
                     rep_d   = '0;
                     armed_d = 1'b0;
`endif
                  end else begin
                     state_d = PRESS_PEND;
                     cnt_d   = run_len;
                  end
               end
            end
            PRESSED, RELEASE_PEND: begin
               if (btn_sync) begin
`ifdef BTN_AUTOREPEAT_EN
                  if (state_q == PRESSED) begin
                     if (rep_inc == (armed_q ? PERIOD_CNT : DELAY_CNT)) begin
                        press_d = 1'b1;
                        rep_d   = '0;
                        armed_d = 1'b1;
                     end else begin
                        rep_d   = rep_inc;
                     end
                  end
`endif
                  state_d = PRESSED;
                  cnt_d   = '0;
               end else begin
                  if (state_q == PRESSED) begin
                     run_len = CNT_W'(1);
                  end
                  if (run_len == STABLE_CNT) begin
                     state_d   = RELEASED;
                     cnt_d     = '0;
                     level_d   = 1'b0;
                     release_d = 1'b1;
`ifdef BTN_AUTOREPEAT_EN
                     rep_d     = '0;
                     armed_d   = 1'b0;
`endif
                  end else begin
                     state_d = RELEASE_PEND;
                     cnt_d   = run_len;
                  end
               end
            end
            default: begin
               state_d = RELEASED;
               cnt_d   = '0;
            end
         endcase
      end
   end

   // State, counter and registered output flops with asynchronous reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= RELEASED;
         cnt_q     <= '0;
         level_q   <= 1'b0;
         press_q   <= 1'b0;
         release_q <= 1'b0;
`ifdef BTN_AUTOREPEAT_EN
         rep_q     <= '0;
         armed_q   <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         level_q   <= level_d;
         press_q   <= press_d;
         release_q <= release_d;
`ifdef BTN_AUTOREPEAT_EN
         rep_q     <= rep_d;
         armed_q   <= armed_d;
`endif
      end
   end

   assign btn_level   = level_q;
   assign btn_press   = press_q;
   assign btn_release = release_q;

endmodule

// File: rtl/btn_debouncer.sv
// btn_debouncer: synchronises the sampling strobe and raw buttons into clk,
// derives a one-cycle sample_tick and runs one btn_fsm per button.
// Optional feature macro: BTN_AUTOREPEAT_EN (auto-repeat press pulses).
module btn_debouncer
   import btn_pkg::*;
#(
   parameter int N_BTN          = 5,
   parameter int STABLE_SAMPLES = 4,
   parameter int REPEAT_DELAY   = 50,
   parameter int REPEAT_PERIOD  = 10
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             sample_clk,
   input  logic [N_BTN-1:0] btn_raw,
   output logic [N_BTN-1:0] btn_level,
   output logic [N_BTN-1:0] btn_press,
   output logic [N_BTN-1:0] btn_release
);

   if (STABLE_SAMPLES < 1 || STABLE_SAMPLES > 15 ||
       REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_param
      $error("btn_debouncer: parameter out of legal range");
   end

   logic             samp_meta_q, samp_meta_d;
   logic             samp_sync_q, samp_sync_d;
   logic             samp_prev_q, samp_prev_d;
   logic [N_BTN-1:0] btn_meta_q, btn_meta_d;
   logic [N_BTN-1:0] btn_sync_q, btn_sync_d;
   logic             sample_tick;

   // Synchroniser shift and rising-edge detection of the divided clock.
   always_comb begin
      samp_meta_d = sample_clk;
      samp_sync_d = samp_meta_q;
      samp_prev_d = samp_sync_q;
      btn_meta_d  = btn_raw;
      btn_sync_d  = btn_meta_q;
      sample_tick = samp_sync_q & ~samp_prev_q;
   end

   // Two-flop synchronisers plus the edge-detector history flop.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         samp_meta_q <= 1'b0;
         samp_sync_q <= 1'b0;
         samp_prev_q <= 1'b0;
         btn_meta_q  <= '0;
         btn_sync_q  <= '0;
      end else begin
         samp_meta_q <= samp_meta_d;
         samp_sync_q <= samp_sync_d;
         samp_prev_q <= samp_prev_d;
         btn_meta_q  <= btn_meta_d;
         btn_sync_q  <= btn_sync_d;
      end
   end

   for (genvar i = 0; i < N_BTN; i++) begin : g_btn
      btn_fsm #(
         .STABLE_SAMPLES (STABLE_SAMPLES)
`ifdef BTN_AUTOREPEAT_EN
         ,
         .REPEAT_DELAY   (REPEAT_DELAY),
         .REPEAT_PERIOD  (REPEAT_PERIOD)
`endif
      ) u_fsm (
         .clk         (clk),
         .rst         (rst),
         .sample_tick (sample_tick),
         .btn_sync    (btn_sync_q[i]),
         .btn_level   (btn_level[i]),
         .btn_press   (btn_press[i]),
         .btn_release (btn_release[i])
      );
   end

endmodule
